alu_req_sched: RTL and testbench

Round-robin scheduler that shares one registered ALU datapath among `NUM_REQ` requesters. It accepts operations over per-requester valid/ready handshakes and drives the ALU operand and opcode inputs. It tracks the ALU's one-cycle result latency and returns each tagged result through a 2-entry response FIFO with backpressure. It sits between the requester bus and the ALU instance.

---
 rtl/alu_pkg.sv | 15 +
 rtl/rr_pick.sv | 29 ++
 rtl/alu_req_sched.sv | 110 +++++++++++
 tb/tb_alu_req_sched.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and opcode width.
package alu_pkg;

  localparam int OP_W = 3;

  localparam logic [OP_W-1:0] OP_ADD    = 3'b000;
  localparam logic [OP_W-1:0] OP_SUB    = 3'b001;
  localparam logic [OP_W-1:0] OP_XOR    = 3'b010;
  localparam logic [OP_W-1:0] OP_AND    = 3'b011;
  localparam logic [OP_W-1:0] OP_OR     = 3'b100;
  localparam logic [OP_W-1:0] OP_MULT   = 3'b101;
  localparam logic [OP_W-1:0] OP_LSHIFT = 3'b110;
  localparam logic [OP_W-1:0] OP_RSHIFT = 3'b111;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first valid requester at or above ptr,
// wrapping around.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_valid,
  input  logic [ID_W-1:0]    ptr,
  output logic               any,
  output logic [ID_W-1:0]    winner
);

  logic [ID_W-1:0] idx;

  // Scan from farthest to nearest so the nearest valid wins.
  always_comb begin
    any    = 1'b0;
    winner = '0;
    idx    = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = ptr + ID_W'(k);
      if (req_valid[idx]) begin
        any    = 1'b1;
        winner = idx;
      end
    end
  end

endmodule

// File: rtl/alu_req_sched.sv
// Round-robin scheduler sharing one registered ALU among NUM_REQ
// requesters, with a 2-entry tagged response FIFO.
module alu_req_sched
  import alu_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int NUM_REQ    = 4,
  parameter int ID_W       = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [OP_W*NUM_REQ-1:0]       req_opcode,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_a,
  input  logic [DATA_WIDTH*NUM_REQ-1:0] req_b,
  output logic [OP_W-1:0]               alu_opcode,
  output logic [DATA_WIDTH-1:0]         alu_operand_a,
  output logic [DATA_WIDTH-1:0]         alu_operand_b,
  input  logic [2*DATA_WIDTH-1:0]       alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [ID_W-1:0]               rsp_id,
  output logic [2*DATA_WIDTH-1:0]       rsp_result,
  output logic                          busy
);

  localparam int RW = 2 * DATA_WIDTH;

  logic            f;
  logic [ID_W-1:0] f_id;
  logic [ID_W-1:0] ptr;
  logic [1:0]      cnt;
  logic            wr_p;
  logic            rd_p;
  logic [ID_W-1:0] ent_id  [2];
  logic [RW-1:0]   ent_res [2];

  logic            any;
  logic [ID_W-1:0] winner;
  logic [2:0]      occ;
  logic            pop;
  logic            issue;
  int unsigned     sel;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .req_valid (req_valid),
    .ptr       (ptr),
    .any       (any),
    .winner    (winner)
  );

  assign occ = {1'b0, cnt} + {2'b0, f};
  assign pop = rsp_valid & rsp_ready;
  // A slot must exist for every result in flight; reset blocks issue.
  assign issue = rst_n & any & ((occ - {2'b0, pop}) <= 3'd1);
  assign sel = int'(winner);

  always_comb begin
    req_ready     = '0;
    alu_opcode    = '0;
    alu_operand_a = '0;
    alu_operand_b = '0;
    if (issue) begin
      req_ready[winner] = 1'b1;
      alu_opcode    = req_opcode[sel*OP_W +: OP_W];
      alu_operand_a = req_a[sel*DATA_WIDTH +: DATA_WIDTH];
      alu_operand_b = req_b[sel*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  assign rsp_valid  = (cnt != 2'd0);
  assign rsp_id     = ent_id[rd_p];
  assign rsp_result = ent_res[rd_p];
  assign busy       = (occ != 3'd0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      f          <= 1'b0;
      f_id       <= '0;
      ptr        <= '0;
      cnt        <= '0;
      wr_p       <= 1'b0;
      rd_p       <= 1'b0;
      ent_id[0]  <= '0;
      ent_id[1]  <= '0;
      ent_res[0] <= '0;
      ent_res[1] <= '0;
    end else begin
      f <= issue;
      if (issue) begin
        f_id <= winner;
        ptr  <= winner + 1'b1;
      end
      if (f) begin
        ent_id[wr_p]  <= f_id;
        ent_res[wr_p] <= alu_result;
        wr_p          <= ~wr_p;
      end
      if (pop) begin
        rd_p <= ~rd_p;
      end
      cnt <= cnt + {1'b0, f} - {1'b0, pop};
    end
  end

endmodule

// File: tb/tb_alu_req_sched.sv
// Self-checking bench for alu_req_sched: directed vectors, corner
// sequences and a randomized run against a queue-based reference model.
module tb_alu_req_sched;
  import alu_pkg::*;

  localparam int DW = 8;
  localparam int N  = 4;
  localparam int IW = 2;
  localparam int RW = 16;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [3*N-1:0]    req_opcode;
  logic [DW*N-1:0]   req_a;
  logic [DW*N-1:0]   req_b;
  logic [2:0]        alu_opcode;
  logic [DW-1:0]     alu_operand_a;
  logic [DW-1:0]     alu_operand_b;
  logic [RW-1:0]     alu_result;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [IW-1:0]     rsp_id;
  logic [RW-1:0]     rsp_result;
  logic              busy;

  alu_req_sched #(
    .DATA_WIDTH (DW),
    .NUM_REQ    (N),
    .ID_W       (IW)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_opcode    (req_opcode),
    .req_a         (req_a),
    .req_b         (req_b),
    .alu_opcode    (alu_opcode),
    .alu_operand_a (alu_operand_a),
    .alu_operand_b (alu_operand_b),
    .alu_result    (alu_result),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_id        (rsp_id),
    .rsp_result    (rsp_result),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] alu_f(logic [2:0] op,
                                          logic [DW-1:0] a,
                                          logic [DW-1:0] b);
    logic [RW-1:0] x, y;
    x = RW'(a);
    y = RW'(b);
    case (op)
      OP_ADD:    return x + y;
      OP_SUB:    return x - y;
      OP_XOR:    return x ^ y;
      OP_AND:    return x & y;
      OP_OR:     return x | y;
      OP_MULT:   return x * y;
      OP_LSHIFT: return x << b;
      default:   return x >> b;
    endcase
  endfunction

  // Registered ALU stand-in: one-cycle latency.
  always @(posedge clk) alu_result <= alu_f(alu_opcode, alu_operand_a, alu_operand_b);

  typedef struct {
    logic [IW-1:0] id;
    logic [RW-1:0] res;
    int            k;
  } exp_t;

  exp_t   q[$];
  int     grants[$];
  int     e;
  int     last;
  int     checks;
  int     errors;
  logic [N-1:0] acc;
  logic   pend [N];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", name, act, exp, e);
    end
  endtask

  task automatic set_req(int i, logic v, logic [2:0] op,
                         logic [DW-1:0] a, logic [DW-1:0] b);
    req_valid[i]         = v;
    req_opcode[3*i +: 3] = op;
    req_a[DW*i +: DW]    = a;
    req_b[DW*i +: DW]    = b;
  endtask

  // One cycle: called at a negedge with inputs already driven.
  task automatic step();
    int   w, sz;
    logic exp_rv, p, allowed;
    logic [N-1:0] exp_rr;
    logic [2:0] op;
    #1;
    w = -1;
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (last + 1 + k) % N;
      if (req_valid[idx] && w < 0) w = idx;
    end
    sz     = q.size();
    exp_rv = (sz > 0) && (q[0].k + 1 <= e);
    chk("rsp_valid", 32'(rsp_valid), 32'(exp_rv));
    chk("busy", 32'(busy), 32'(sz != 0));
    p = exp_rv & rsp_ready;
    if (p) begin
      chk("rsp_id", 32'(rsp_id), 32'(q[0].id));
      chk("rsp_result", 32'(rsp_result), 32'(q[0].res));
      void'(q.pop_front());
    end
    allowed = (sz - int'(p)) <= 1;
    exp_rr  = '0;
    if (w >= 0 && allowed) exp_rr[w] = 1'b1;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    acc = exp_rr & req_valid;
    if (acc != '0) begin
      op = req_opcode[3*w +: 3];
      q.push_back('{id: IW'(w),
                    res: alu_f(op, req_a[DW*w +: DW], req_b[DW*w +: DW]),
                    k: e + 1});
      last = w;
      grants.push_back(w);
    end
    @(posedge clk);
    e++;
    @(negedge clk);
  endtask

  task automatic chk_zero();
    chk("rst req_ready", 32'(req_ready), 0);
    chk("rst alu_opcode", 32'(alu_opcode), 0);
    chk("rst alu_a", 32'(alu_operand_a), 0);
    chk("rst alu_b", 32'(alu_operand_b), 0);
    chk("rst rsp_valid", 32'(rsp_valid), 0);
    chk("rst rsp_id", 32'(rsp_id), 0);
    chk("rst rsp_result", 32'(rsp_result), 0);
    chk("rst busy", 32'(busy), 0);
  endtask

  task automatic drain();
    int t;
    req_valid = '0;
    rsp_ready = 1'b1;
    t = 0;
    while (q.size() != 0 && t < 10) begin
      step();
      t++;
    end
    chk("drain", 32'(q.size()), 0);
  endtask

  task automatic run_one(int id, logic [2:0] op, logic [DW-1:0] a,
                         logic [DW-1:0] b, logic [RW-1:0] res);
    int t;
    rsp_ready = 1'b1;
    set_req(id, 1'b1, op, a, b);
    t = 0;
    do begin
      step();
      t++;
    end while (!acc[id] && t < 8);
    chk("accept", 32'(acc[id]), 1);
    req_valid[id] = 1'b0;
    step();
    chk("vec rsp_valid", 32'(rsp_valid), 1);
    chk("vec rsp_id", 32'(rsp_id), 32'(id));
    chk("vec rsp_result", 32'(rsp_result), 32'(res));
    step();
  endtask

  typedef struct {
    int            id;
    logic [2:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [RW-1:0] res;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t, n0;
    checks = 0;
    errors = 0;
    e      = 0;
    last   = N - 1;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_opcode = '0;
    req_a      = '0;
    req_b      = '0;
    rsp_ready  = 1'b0;
    #1;
    chk_zero();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    vecs[0] = '{2, OP_ADD,    8'h05, 8'h03, 16'h0008};
    vecs[1] = '{1, OP_SUB,    8'h03, 8'h05, 16'hFFFE};
    vecs[2] = '{0, OP_XOR,    8'hF0, 8'h3C, 16'h00CC};
    vecs[3] = '{3, OP_AND,    8'hF0, 8'h3C, 16'h0030};
    vecs[4] = '{2, OP_OR,     8'hF0, 8'h3C, 16'h00FC};
    vecs[5] = '{1, OP_MULT,   8'hFF, 8'hFF, 16'hFE01};
    vecs[6] = '{0, OP_LSHIFT, 8'h81, 8'h04, 16'h0810};
    vecs[7] = '{3, OP_RSHIFT, 8'h81, 8'h04, 16'h0008};
    for (int i = 0; i < 8; i++)
      run_one(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res);

    // Round robin with everyone valid.
    grants.delete();
    for (int i = 0; i < N; i++) set_req(i, 1'b1, OP_ADD, DW'(i), DW'(i + 16));
    rsp_ready = 1'b1;
    for (int c = 0; c < 8; c++) step();
    chk("rr count", 32'(grants.size()), 8);
    for (int j = 0; j < 8 && j < grants.size(); j++)
      chk("rr order", 32'(grants[j]), 32'(j % N));
    drain();

    // Backpressure: only two accepts while rsp_ready is low.
    grants.delete();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_MULT, 8'hFF, 8'hFF);
    for (int c = 0; c < 6; c++) step();
    chk("bp accepts", 32'(grants.size()), 2);
    chk("bp busy", 32'(busy), 1);
    rsp_ready = 1'b1;
    for (int c = 0; c < 6; c++) step();
    chk("bp resumed", 32'(grants.size()), 8);
    drain();

    // Push + pop + issue together in steady state.
    rsp_ready = 1'b1;
    set_req(1, 1'b1, OP_SUB, 8'h40, 8'h01);
    set_req(2, 1'b1, OP_XOR, 8'h55, 8'hAA);
    for (int c = 0; c < 6; c++) step();
    chk("steady busy", 32'(busy), 1);
    drain();

    // Reset with two operations outstanding.
    grants.delete();
    rsp_ready = 1'b0;
    set_req(0, 1'b1, OP_MULT, 8'h12, 8'h34);
    t = 0;
    while (grants.size() < 2 && t < 8) begin
      step();
      t++;
    end
    chk("pre-rst accepts", 32'(grants.size()), 2);
    rst_n = 1'b0;
    #1;
    chk_zero();
    q.delete();
    last = N - 1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    req_valid = '0;
    step();
    run_one(0, OP_ADD, 8'h10, 8'h20, 16'h0030);

    // Pointer wrap: ptr parked at 3, then 3 and 0 compete.
    run_one(2, OP_ADD, 8'h01, 8'h01, 16'h0002);
    grants.delete();
    rsp_ready = 1'b1;
    set_req(3, 1'b1, OP_ADD, 8'h03, 8'h00);
    set_req(0, 1'b1, OP_ADD, 8'h00, 8'h00);
    step();
    if (acc[3]) req_valid[3] = 1'b0;
    step();
    req_valid = '0;
    chk("wrap count", 32'(grants.size()), 2);
    if (grants.size() == 2) begin
      chk("wrap first", 32'(grants[0]), 3);
      chk("wrap second", 32'(grants[1]), 0);
    end
    drain();

    // Randomized traffic with hold-until-accept requesters.
    for (int i = 0; i < N; i++) pend[i] = 1'b0;
    n0 = grants.size();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && ($urandom % 2 == 0)) begin
          pend[i] = 1'b1;
          set_req(i, 1'b1, 3'($urandom), 8'($urandom), 8'($urandom));
        end
      end
      rsp_ready = ($urandom % 10) < 7;
      step();
      for (int i = 0; i < N; i++) begin
        if (acc[i]) begin
          pend[i]      = 1'b0;
          req_valid[i] = 1'b0;
        end
      end
    end
    chk("random progress", 32'(grants.size() > n0 + 100), 1);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
